// File: rtl/pc_fetch.sv
// ---------------------------------------------------------------------------
// pc_fetch
//   Program-counter and byte-fetch sequencer for the 8-bit CPU. Owns the
//   16-bit PC, issues single-byte reads to program memory through a
//   request/ready handshake and latches each returned byte into ir.
//   Jump targets from the jump unit are loaded verbatim when jmp_pcoe is high.
//
// Parameters
//   RESET_VEC   PC value loaded on reset
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   fetch       in   request the next byte at the current PC (level)
//   halt        in   blocks the start of new fetches
//   jmp_pcoe    in   jump taken, load jmp_pc into the PC
//   jmp_pc      in   [15:0] jump target
//   mem_ready   in   memory presents valid mem_data this cycle
//   mem_data    in   [7:0] byte from program memory
//   mem_req     out  read request, held until accepted (registered)
//   mem_addr    out  [15:0] read address (registered)
//   pc          out  [15:0] current program counter (registered)
//   ir          out  [7:0] last fetched byte (registered)
//   byte_valid  out  one-cycle pulse, ir updated this cycle (registered)
//   busy        out  a fetch is outstanding (registered)
// ---------------------------------------------------------------------------
module pc_fetch #(
    parameter logic [15:0] RESET_VEC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch,
    input  logic        halt,
    input  logic        jmp_pcoe,
    input  logic [15:0] jmp_pc,
    input  logic        mem_ready,
    input  logic [7:0]  mem_data,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic [15:0] pc,
    output logic [7:0]  ir,
    output logic        byte_valid,
    output logic        busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [15:0] pc_s;
    logic [7:0]  ir_s;
    logic        byte_valid_s;
    logic        req_s;

    // Next-state, next-PC and next-IR decode for the two-state fetch FSM.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc;
        ir_s         = ir;
        byte_valid_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // A jump in IDLE suppresses fetch start for this cycle so the
                // next request is issued from the new PC.
                if (jmp_pcoe) begin
                    pc_s    = jmp_pc;
                    state_s = ST_IDLE;
                end else if (fetch && !halt) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    ir_s         = mem_data;
                    byte_valid_s = 1'b1;
                    state_s      = ST_IDLE;
                    // Jump takes priority over the sequential increment.
                    if (jmp_pcoe) begin
                        pc_s = jmp_pc;
                    end else begin
                        pc_s = pc + 16'd1;
                    end
                end else if (jmp_pcoe) begin
                    // Abort: drop the request, no byte delivered.
                    pc_s    = jmp_pc;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_REQ;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        req_s = (state_s == ST_REQ);
    end

    // State and registered outputs; mem_addr tracks the next PC so it is
    // already valid on the cycle the request is raised.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            pc         <= RESET_VEC;
            mem_addr   <= RESET_VEC;
            ir         <= 8'h00;
            mem_req    <= 1'b0;
            busy       <= 1'b0;
            byte_valid <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc         <= pc_s;
            mem_addr   <= pc_s;
            ir         <= ir_s;
            mem_req    <= req_s;
            busy       <= req_s;
            byte_valid <= byte_valid_s;
        end
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and byte-fetch sequencer for the 8-bit CPU. It owns the 16-bit PC, issues byte reads to program memory through a request/ready handshake, and latches each returned byte for the control unit. It sits directly upstream and downstream of the jump unit. It supplies `pc` as the jump unit's PC input and loads the jump unit's target (`jmp_pc`) whenever the jump unit asserts `jmp_pcoe`.

## Interface
Parameters:
- `RESET_VEC`, default 16'h0000: PC value loaded on reset.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `fetch`  in  1  control unit requests the next byte at the current PC.
- `halt`  in  1  blocks the start of new fetches.
- `jmp_pcoe`  in  1  jump taken; load `jmp_pc` into the PC.
- `jmp_pc`  in  16  jump target from the jump unit.
- `mem_ready`  in  1  memory has valid `mem_data` this cycle.
- `mem_data`  in  8  byte read from program memory.
- `mem_req`  out  1  read request, held until accepted.
- `mem_addr`  out  16  read address.
- `pc`  out  16  current program counter; feeds the jump unit.
- `ir`  out  8  last fetched byte.
- `byte_valid`  out  1  one-cycle pulse; `ir` was updated this cycle.
- `busy`  out  1  high while a fetch is outstanding.

## Operation
- The FSM has two states, IDLE and REQ.
- **IDLE**
  - If `fetch & !halt & !jmp_pcoe`, go to REQ.
  - Otherwise, stay in IDLE.
- **REQ**
  - `mem_req` = 1, `mem_addr` = `pc`, `busy` = 1.
  - If `mem_ready` and not `jmp_pcoe`: set `ir <= mem_data` and `pc <= pc + 1`, pulse `byte_valid`, go to IDLE.
  - If `mem_ready` and `jmp_pcoe`: set `ir <= mem_data` and `pc <= jmp_pc`, pulse `byte_valid`, go to IDLE. The jump wins over the increment.
  - If `jmp_pcoe` without `mem_ready`: abort. Set `pc <= jmp_pc`, go to IDLE, no `byte_valid`, `ir` unchanged.
  - Otherwise, stay in REQ with `pc` stable.
- **Jumps in IDLE:** `jmp_pcoe` in IDLE sets `pc <= jmp_pc`. If `fetch` is also high that cycle, the fetch is not started. It starts next cycle from the new PC if `fetch` is still high.
- **Halt:** `halt` only blocks the IDLE→REQ transition. A REQ already in progress completes normally.
- **PC arithmetic:** the increment is modulo 2^16, so 16'hFFFF + 1 = 16'h0000 with no flag. `jmp_pc` is loaded verbatim; relative-offset addition is done in the jump unit.
- **Fetch consumption:** `fetch` is a level. Each accepted fetch consumes exactly one byte. If the control unit holds `fetch` high, back-to-back fetches follow.
- **Registered outputs:** `mem_req`, `mem_addr`, `pc`, `ir`, `byte_valid` and `busy` are all registered, with no combinational path from inputs.
- **Reset values:** `pc` = RESET_VEC, `mem_addr` = RESET_VEC, `ir` = 8'h00, `mem_req` = 0, `byte_valid` = 0, `busy` = 0, state IDLE.
- **Reset mid-fetch:** `rst` asserted during REQ drops `mem_req` immediately (asynchronously). Any `mem_ready` arriving afterwards is ignored.

## Timing
- **Fetch start:** `fetch` sampled high at edge N in IDLE gives `mem_req` = 1 after edge N.
- **Zero-wait memory:** with `mem_ready` high at edge N+1:
  - `ir`, `pc` and `byte_valid` update after edge N+1.
  - `mem_req` falls after edge N+1.
  - Throughput is one byte per 2 cycles.
- **Wait states:** each cycle of `mem_ready` low adds one cycle. `mem_addr` and `mem_req` stay stable throughout.
- **`byte_valid` pulse:** exactly one cycle wide, coincident with the new `ir` value.
- **Jump load:** `pc` reflects `jmp_pc` the cycle after the edge at which `jmp_pcoe` is sampled.
- **Stray `mem_ready`:** `mem_ready` while `mem_req` = 0 is ignored.

## Test plan
- **Reset and sequential fetch:** reset with RESET_VEC = 16'h0100; memory returns 8'hA5, 8'h3C with zero wait; `fetch` held high. Expect `mem_addr` 0100 then 0101, `ir` A5 then 3C, two `byte_valid` pulses 2 cycles apart, final `pc` = 16'h0102.
- **Wait states:** `mem_ready` delayed 3 cycles. Expect `mem_req` high for 4 cycles, `mem_addr` stable, a single `byte_valid` pulse, `pc` +1.
- **Wrap-around:** `jmp_pc` = 16'hFFFF loaded, then one fetch. Expect `mem_addr` = FFFF and `pc` = 16'h0000 afterwards.
- **Jump vs increment:** `jmp_pcoe` with `jmp_pc` = 16'h1234 in the same cycle as `mem_ready` (data 8'h77). Expect `ir` = 77, `byte_valid` pulse, `pc` = 1234.
- **Abort and halt:**
  - `jmp_pcoe` (target 16'h2000) during REQ with no `mem_ready`: expect `mem_req` drops, no `byte_valid`, `pc` = 2000.
  - `halt` high with `fetch` high: expect no `mem_req`.
- **Async reset mid-REQ:** assert `rst` between edges during REQ. Expect `mem_req` = 0 immediately and `pc` = RESET_VEC; a later `mem_ready` has no effect.
